// File: rtl/hazard_if.sv
// Bundle of pipeline-side signals exchanged with the hazard/forwarding unit.
// The master modport is the pipeline; the slave modport is the unit.
interface hazard_if #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 32
);
  logic [REG_ADDR_W-1:0]  rs1_address_id_i;
  logic [REG_ADDR_W-1:0]  rs2_address_id_i;
  logic                   rs1_used_id_i;
  logic                   rs2_used_id_i;
  logic [REG_ADDR_W-1:0]  rd_address_id_i;
  logic                   rd_we_id_i;
  logic                   branch_id_i;
  logic                   div_op_id_i;
  logic [REG_ADDR_W-1:0]  rs1_address_ex_i;
  logic [REG_ADDR_W-1:0]  rs2_address_ex_i;
  logic [REG_ADDR_W-1:0]  rd_address_ex_i;
  logic                   rd_we_ex_i;
  logic                   mem_to_reg_ex_i;
  logic                   div_issue_ex_i;
  logic [REG_ADDR_W-1:0]  rd_address_mem_i;
  logic                   rd_we_mem_i;
  logic                   mem_to_reg_mem_i;
  logic [REG_ADDR_W-1:0]  rd_address_wb_i;
  logic                   rd_we_wb_i;
  logic [1:0]             alu_forward_a_o;
  logic [1:0]             alu_forward_b_o;
  logic [1:0]             branch_forward_a_o;
  logic [1:0]             branch_forward_b_o;
  logic                   stall_o;
  logic                   bubble_ex_o;
  logic                   div_busy_o;
  logic [STALL_CNT_W-1:0] stall_count_o;

  modport master (
    output rs1_address_id_i, rs2_address_id_i, rs1_used_id_i, rs2_used_id_i,
           rd_address_id_i, rd_we_id_i, branch_id_i, div_op_id_i,
           rs1_address_ex_i, rs2_address_ex_i, rd_address_ex_i, rd_we_ex_i,
           mem_to_reg_ex_i, div_issue_ex_i, rd_address_mem_i, rd_we_mem_i,
           mem_to_reg_mem_i, rd_address_wb_i, rd_we_wb_i,
    input  alu_forward_a_o, alu_forward_b_o, branch_forward_a_o, branch_forward_b_o,
           stall_o, bubble_ex_o, div_busy_o, stall_count_o
  );

  modport slave (
    input  rs1_address_id_i, rs2_address_id_i, rs1_used_id_i, rs2_used_id_i,
           rd_address_id_i, rd_we_id_i, branch_id_i, div_op_id_i,
           rs1_address_ex_i, rs2_address_ex_i, rd_address_ex_i, rd_we_ex_i,
           mem_to_reg_ex_i, div_issue_ex_i, rd_address_mem_i, rd_we_mem_i,
           mem_to_reg_mem_i, rd_address_wb_i, rd_we_wb_i,
    output alu_forward_a_o, alu_forward_b_o, branch_forward_a_o, branch_forward_b_o,
           stall_o, bubble_ex_o, div_busy_o, stall_count_o
  );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// Operand forwarding selects and load-use / branch / divider stalls for the
// 5-stage rv32im_zbb pipeline, with a one-entry divide scoreboard and stall counter.
module hazard_forwarding_unit #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned DIV_LATENCY = 34,
  parameter int unsigned STALL_CNT_W = 32
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(DIV_LATENCY);
  localparam logic [1:0]  FWD_RF  = 2'b00;
  localparam logic [1:0]  FWD_WB  = 2'b01;
  localparam logic [1:0]  FWD_MEM = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [REG_ADDR_W-1:0] pend_addr;
  logic [REG_ADDR_W-1:0] pend_next;
  logic                  load_use;
  logic                  branch_stall;
  logic                  raw_hit;
  logic                  waw_hit;
  logic                  sb_stall;
  logic                  stall;

  function automatic logic match(input logic [REG_ADDR_W-1:0] src,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic                  we);
    return we && (rd != '0) && (src == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    return mem_hit ? FWD_MEM : (wb_hit ? FWD_WB : FWD_RF);
  endfunction

  // ALU operands see EX sources; branch operands are compared in ID and cannot take a MEM load
  assign bus.alu_forward_a_o = fwd_sel(
    match(bus.rs1_address_ex_i, bus.rd_address_mem_i, bus.rd_we_mem_i),
    match(bus.rs1_address_ex_i, bus.rd_address_wb_i, bus.rd_we_wb_i));
  assign bus.alu_forward_b_o = fwd_sel(
    match(bus.rs2_address_ex_i, bus.rd_address_mem_i, bus.rd_we_mem_i),
    match(bus.rs2_address_ex_i, bus.rd_address_wb_i, bus.rd_we_wb_i));
  assign bus.branch_forward_a_o = fwd_sel(
    match(bus.rs1_address_id_i, bus.rd_address_mem_i, bus.rd_we_mem_i) && !bus.mem_to_reg_mem_i,
    match(bus.rs1_address_id_i, bus.rd_address_wb_i, bus.rd_we_wb_i));
  assign bus.branch_forward_b_o = fwd_sel(
    match(bus.rs2_address_id_i, bus.rd_address_mem_i, bus.rd_we_mem_i) && !bus.mem_to_reg_mem_i,
    match(bus.rs2_address_id_i, bus.rd_address_wb_i, bus.rd_we_wb_i));

  assign load_use = bus.mem_to_reg_ex_i &&
    ((bus.rs1_used_id_i && match(bus.rs1_address_id_i, bus.rd_address_ex_i, bus.rd_we_ex_i)) ||
     (bus.rs2_used_id_i && match(bus.rs2_address_id_i, bus.rd_address_ex_i, bus.rd_we_ex_i)));

  assign branch_stall = bus.branch_id_i &&
    ((bus.rs1_used_id_i &&
      (match(bus.rs1_address_id_i, bus.rd_address_ex_i, bus.rd_we_ex_i) ||
       (match(bus.rs1_address_id_i, bus.rd_address_mem_i, bus.rd_we_mem_i) && bus.mem_to_reg_mem_i))) ||
     (bus.rs2_used_id_i &&
      (match(bus.rs2_address_id_i, bus.rd_address_ex_i, bus.rd_we_ex_i) ||
       (match(bus.rs2_address_id_i, bus.rd_address_mem_i, bus.rd_we_mem_i) && bus.mem_to_reg_mem_i))));

  // A pending divide into x0 has no architectural result to protect
  assign raw_hit = (pend_addr != '0) &&
    ((bus.rs1_used_id_i && (bus.rs1_address_id_i == pend_addr)) ||
     (bus.rs2_used_id_i && (bus.rs2_address_id_i == pend_addr)));
  assign waw_hit  = (pend_addr != '0) && bus.rd_we_id_i && (bus.rd_address_id_i == pend_addr);
  assign sb_stall = (state == BUSY) && (bus.div_op_id_i || raw_hit || waw_hit);

  assign stall           = load_use || branch_stall || sb_stall;
  assign bus.stall_o     = stall;
  assign bus.bubble_ex_o = stall;
  assign bus.div_busy_o  = (state == BUSY);

  // Divider occupancy: issue is only accepted from IDLE
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend_addr;
    case (state)
      IDLE: begin
        if (bus.div_issue_ex_i) begin
          state_next = BUSY;
          pend_next  = bus.rd_address_ex_i;
          cnt_next   = CNT_W'(DIV_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next = IDLE;
          pend_next  = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      pend_addr         <= '0;
      bus.stall_count_o <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pend_addr <= pend_next;
      if (stall && (bus.stall_count_o != '1)) begin
        bus.stall_count_o <= bus.stall_count_o + STALL_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed bench for hazard_forwarding_unit: combinational vector table plus
// clocked sequences for the divider scoreboard, reset and counter saturation.
module tb_hazard_forwarding_unit;
  logic clk;
  logic reset;

  hazard_if #(.REG_ADDR_W(5), .STALL_CNT_W(3)) bus ();

  hazard_forwarding_unit #(
    .REG_ADDR_W (5),
    .DIV_LATENCY(4),
    .STALL_CNT_W(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic [1:0] used;    // {rs2_used, rs1_used}
    logic [4:0] rd_id;
    logic       we_id;
    logic       br;
    logic       div;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic [4:0] rd_ex;
    logic       we_ex;
    logic       ld_ex;
    logic [4:0] rd_mem;
    logic       we_mem;
    logic       ld_mem;
    logic [4:0] rd_wb;
    logic       we_wb;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] ba;
    logic [1:0] bb;
    logic       stall;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rs1_address_id_i = '0; bus.rs2_address_id_i = '0;
    bus.rs1_used_id_i = 1'b0;  bus.rs2_used_id_i = 1'b0;
    bus.rd_address_id_i = '0;  bus.rd_we_id_i = 1'b0;
    bus.branch_id_i = 1'b0;    bus.div_op_id_i = 1'b0;
    bus.rs1_address_ex_i = '0; bus.rs2_address_ex_i = '0;
    bus.rd_address_ex_i = '0;  bus.rd_we_ex_i = 1'b0;
    bus.mem_to_reg_ex_i = 1'b0; bus.div_issue_ex_i = 1'b0;
    bus.rd_address_mem_i = '0; bus.rd_we_mem_i = 1'b0; bus.mem_to_reg_mem_i = 1'b0;
    bus.rd_address_wb_i = '0;  bus.rd_we_wb_i = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.rs1_address_id_i = v.rs1_id; bus.rs2_address_id_i = v.rs2_id;
    bus.rs1_used_id_i = v.used[0];   bus.rs2_used_id_i = v.used[1];
    bus.rd_address_id_i = v.rd_id;   bus.rd_we_id_i = v.we_id;
    bus.branch_id_i = v.br;          bus.div_op_id_i = v.div;
    bus.rs1_address_ex_i = v.rs1_ex; bus.rs2_address_ex_i = v.rs2_ex;
    bus.rd_address_ex_i = v.rd_ex;   bus.rd_we_ex_i = v.we_ex;
    bus.mem_to_reg_ex_i = v.ld_ex;   bus.div_issue_ex_i = 1'b0;
    bus.rd_address_mem_i = v.rd_mem; bus.rd_we_mem_i = v.we_mem; bus.mem_to_reg_mem_i = v.ld_mem;
    bus.rd_address_wb_i = v.rd_wb;   bus.rd_we_wb_i = v.we_wb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic issue_div(input logic [4:0] rd);
    bus.div_issue_ex_i = 1'b1; bus.rd_address_ex_i = rd; bus.rd_we_ex_i = 1'b1;
    next_cycle();
    bus.div_issue_ex_i = 1'b0; bus.rd_address_ex_i = '0; bus.rd_we_ex_i = 1'b0;
  endtask

  initial begin
    //        name              rs1 rs2 use rdid we br dv  r1x r2x rdx wex ldx  rdm wem ldm  rdw wew  fa fb ba bb st
    tbl[0]  = '{"idle",           0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{"alu_mem_pri",    0, 0, 0, 0, 0, 0, 0,  5, 5, 0, 0, 0,  5, 1, 0,  5, 1,  2, 2, 0, 0, 0};
    tbl[2]  = '{"alu_wb_only",    0, 0, 0, 0, 0, 0, 0,  5, 5, 0, 0, 0,  5, 0, 0,  5, 1,  1, 1, 0, 0, 0};
    tbl[3]  = '{"alu_x0",         0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0,  0, 1,  0, 0, 0, 0, 0};
    tbl[4]  = '{"alu_split",      0, 0, 0, 0, 0, 0, 0,  6, 7, 0, 0, 0,  6, 1, 0,  7, 1,  2, 1, 0, 0, 0};
    tbl[5]  = '{"load_use_rs2",   0, 7, 2, 0, 0, 0, 0,  0, 0, 7, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1};
    tbl[6]  = '{"load_use_unused",0, 7, 0, 0, 0, 0, 0,  0, 0, 7, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    tbl[7]  = '{"load_use_rs1",   7, 0, 1, 0, 0, 0, 0,  0, 0, 7, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1};
    tbl[8]  = '{"load_x0",        0, 0, 3, 0, 0, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    tbl[9]  = '{"br_ex_alu",      3, 0, 1, 0, 0, 1, 0,  0, 0, 3, 1, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1};
    tbl[10] = '{"br_mem_alu",     3, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0,  3, 1, 0,  0, 0,  0, 0, 2, 0, 0};
    tbl[11] = '{"br_mem_load",    3, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0,  3, 1, 1,  0, 0,  0, 0, 0, 0, 1};
    tbl[12] = '{"br_wb",          3, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0,  3, 1,  0, 0, 1, 0, 0};
    tbl[13] = '{"brfwd_load_wb",  0, 4, 2, 0, 0, 0, 0,  0, 0, 0, 0, 0,  4, 1, 1,  4, 1,  0, 0, 0, 1, 0};
    tbl[14] = '{"br_ex_load",     0, 3, 2, 0, 0, 1, 0,  0, 0, 3, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1};
    tbl[15] = '{"div_op_idle",    0, 0, 0, 9, 1, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    tbl[16] = '{"br_unused",      3, 0, 0, 0, 0, 1, 0,  0, 0, 3, 1, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 0};

    reset = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_div_busy", 32'(bus.div_busy_o), 0);
    check("rst_stall", 32'(bus.stall_o), 0);
    check("rst_stall_count", 32'(bus.stall_count_o), 0);
    check("rst_alu_fwd_a", 32'(bus.alu_forward_a_o), 0);
    check("rst_br_fwd_b", 32'(bus.branch_forward_b_o), 0);

    // Combinational vector table (divider idle throughout)
    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      apply(tbl[i]);
      @(negedge clk);
      check({tbl[i].name, ".alu_a"}, 32'(bus.alu_forward_a_o), 32'(tbl[i].fa));
      check({tbl[i].name, ".alu_b"}, 32'(bus.alu_forward_b_o), 32'(tbl[i].fb));
      check({tbl[i].name, ".br_a"}, 32'(bus.branch_forward_a_o), 32'(tbl[i].ba));
      check({tbl[i].name, ".br_b"}, 32'(bus.branch_forward_b_o), 32'(tbl[i].bb));
      check({tbl[i].name, ".stall"}, 32'(bus.stall_o), 32'(tbl[i].stall));
      check({tbl[i].name, ".bubble"}, 32'(bus.bubble_ex_o), 32'(tbl[i].stall));
    end

    // Divide to x9, RAW reader in ID: 4 busy/stalled cycles, released in the 5th
    do_reset();
    @(negedge clk);
    check("div_issue_cycle_busy", 32'(bus.div_busy_o), 0);
    #1;
    issue_div(5'd9);
    bus.rs1_address_id_i = 5'd9; bus.rs1_used_id_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("div_raw_busy%0d", i), 32'(bus.div_busy_o), 1);
      check($sformatf("div_raw_stall%0d", i), 32'(bus.stall_o), 1);
      next_cycle();
    end
    @(negedge clk);
    check("div_raw_release_busy", 32'(bus.div_busy_o), 0);
    check("div_raw_release_stall", 32'(bus.stall_o), 0);
    check("div_raw_stall_count", 32'(bus.stall_count_o), 4);

    // Unrelated reader, ignored re-issue, WAW, structural and issue on cnt==0
    do_reset();
    issue_div(5'd9);
    bus.rs1_address_id_i = 5'd10; bus.rs1_used_id_i = 1'b1;
    bus.div_issue_ex_i = 1'b1; bus.rd_address_ex_i = 5'd10; bus.rd_we_ex_i = 1'b1;
    @(negedge clk);
    check("busy1_indep_stall", 32'(bus.stall_o), 0);
    check("busy1_busy", 32'(bus.div_busy_o), 1);
    next_cycle();
    bus.div_issue_ex_i = 1'b0; bus.rd_address_ex_i = '0; bus.rd_we_ex_i = 1'b0;
    @(negedge clk);
    check("busy2_reissue_ignored", 32'(bus.stall_o), 0);
    next_cycle();
    bus.rs1_used_id_i = 1'b0; bus.rd_address_id_i = 5'd9; bus.rd_we_id_i = 1'b1;
    @(negedge clk);
    check("busy3_waw_stall", 32'(bus.stall_o), 1);
    next_cycle();
    bus.rd_we_id_i = 1'b0; bus.div_op_id_i = 1'b1;
    bus.div_issue_ex_i = 1'b1; bus.rd_address_ex_i = 5'd11; bus.rd_we_ex_i = 1'b1;
    @(negedge clk);
    check("busy4_struct_stall", 32'(bus.stall_o), 1);
    check("busy4_busy", 32'(bus.div_busy_o), 1);
    next_cycle();
    clear_inputs();
    bus.div_op_id_i = 1'b1;
    @(negedge clk);
    check("after_last_issue_ignored", 32'(bus.div_busy_o), 0);
    check("after_struct_release", 32'(bus.stall_o), 0);
    next_cycle();
    @(negedge clk);
    check("still_idle", 32'(bus.div_busy_o), 0);

    // Reset asserted on the 2nd busy cycle
    do_reset();
    issue_div(5'd9);
    bus.rs1_address_id_i = 5'd9; bus.rs1_used_id_i = 1'b1;
    next_cycle();
    @(negedge clk);
    check("pre_reset_busy", 32'(bus.div_busy_o), 1);
    check("pre_reset_count", 32'(bus.stall_count_o), 1);
    #1;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_busy", 32'(bus.div_busy_o), 0);
    check("mid_reset_stall", 32'(bus.stall_o), 0);
    check("mid_reset_count", 32'(bus.stall_count_o), 0);

    // Continuous load-use stall saturates the 3-bit counter at 7
    do_reset();
    bus.rs2_address_id_i = 5'd7; bus.rs2_used_id_i = 1'b1;
    bus.rd_address_ex_i = 5'd7;  bus.rd_we_ex_i = 1'b1; bus.mem_to_reg_ex_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("sat_count%0d", i), 32'(bus.stall_count_o), (i < 7) ? i : 7);
      next_cycle();
    end
    @(negedge clk);
    check("sat_hold", 32'(bus.stall_count_o), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
